// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand buffer and sequencer feeding a DIM x DIM systolic array
// Host fills A and B while idle; a start streams column k of A and row k of B per cycle.
module systolic_feeder #(
   parameter int DIM    = 2,
   parameter int ADDR_W = 2,
   parameter int PE_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [31:0]          wr_data,
   input  logic                 start,
   output logic [0:DIM*32-1]    data,
   output logic [0:DIM*32-1]    weight,
   output logic                 feed_valid,
   output logic                 pe_clear,
   output logic                 busy,
   output logic                 done
);

   localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [KW-1:0] K_LAST = KW'(DIM - 1);
   localparam logic [ADDR_W:0] NWORDS = (ADDR_W + 1)'(DIM * DIM);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

   state_t            state;
   logic [KW-1:0]     k;
   logic [KW-1:0]     next_k;
   logic [DW-1:0]     drain_cnt;
   logic [31:0]       a_mem [0:DEPTH-1];
   logic [31:0]       b_mem [0:DEPTH-1];
   logic [0:DIM*32-1] col_a;
   logic [0:DIM*32-1] row_b;

   // Words past DIM*DIM are never written, so they stay zero and are never read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < DEPTH; n++) begin
            a_mem[ADDR_W'(n)] <= '0;
            b_mem[ADDR_W'(n)] <= '0;
         end
      end else if (wr_en && state == IDLE && ({1'b0, wr_addr} < NWORDS)) begin
         if (wr_sel)
            b_mem[wr_addr] <= wr_data;
         else
            a_mem[wr_addr] <= wr_data;
      end
   end

   // Operands are fetched for the step about to be presented, keeping outputs registered.
   always_comb begin
      next_k = (state == STREAM) ? k + 1'b1 : '0;
      col_a  = '0;
      row_b  = '0;
      for (int i = 0; i < DIM; i++) begin
         col_a[i*32 +: 32] = a_mem[ADDR_W'(i * DIM + int'(next_k))];
         row_b[i*32 +: 32] = b_mem[ADDR_W'(int'(next_k) * DIM + i)];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         k          <= '0;
         drain_cnt  <= '0;
         data       <= '0;
         weight     <= '0;
         feed_valid <= 1'b0;
         pe_clear   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         pe_clear <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= CLEAR;
                  pe_clear <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            CLEAR: begin
               state      <= STREAM;
               k          <= '0;
               feed_valid <= 1'b1;
               data       <= col_a;
               weight     <= row_b;
            end
            STREAM: begin
               if (k == K_LAST) begin
                  feed_valid <= 1'b0;
                  data       <= '0;
                  weight     <= '0;
                  if (PE_LAT == 0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state     <= DRAIN;
                     drain_cnt <= DW'(PE_LAT - 1);
                  end
               end else begin
                  k      <= next_k;
                  data   <= col_a;
                  weight <= row_b;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed table-driven bench for systolic_feeder
// u1: DIM=2 PE_LAT=1; u3: DIM=3 ADDR_W=4 PE_LAT=0.
module tb_systolic_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        wr_en, wr_sel, start;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic [0:63] data, weight;
   logic        feed_valid, pe_clear, busy, done;

   logic        wr_en3, wr_sel3, start3;
   logic [3:0]  wr_addr3;
   logic [31:0] wr_data3;
   logic [0:95] data3, weight3;
   logic        fv3, clr3, busy3, done3;

   systolic_feeder #(.DIM(2), .ADDR_W(2), .PE_LAT(1)) u1 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .data(data), .weight(weight),
      .feed_valid(feed_valid), .pe_clear(pe_clear), .busy(busy), .done(done));

   systolic_feeder #(.DIM(3), .ADDR_W(4), .PE_LAT(0)) u3 (
      .clk(clk), .reset(reset), .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_addr(wr_addr3),
      .wr_data(wr_data3), .start(start3), .data(data3), .weight(weight3),
      .feed_valid(fv3), .pe_clear(clr3), .busy(busy3), .done(done3));

   typedef struct {
      logic [31:0] d0, d1, w0, w1;
      logic        clr, fv, bz, dn;
   } vec_t;

   vec_t tbl [6];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] el2(input logic [0:63] v, input int i);
      return v[i*32 +: 32];
   endfunction

   function automatic logic [31:0] el3(input logic [0:95] v, input int i);
      return v[i*32 +: 32];
   endfunction

   task automatic wr(input logic sel, input logic [1:0] addr, input logic [31:0] val);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = val;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wr3(input logic sel, input logic [3:0] addr, input logic [31:0] val);
      wr_en3 = 1'b1; wr_sel3 = sel; wr_addr3 = addr; wr_data3 = val;
      tick();
      wr_en3 = 1'b0;
   endtask

   task automatic load_basic();
      for (int n = 0; n < 4; n++) wr(1'b0, 2'(n), 32'(n + 1));
      for (int n = 0; n < 4; n++) wr(1'b1, 2'(n), 32'(n + 5));
   endtask

   // Row r's start is sampled at edge E_r; outputs checked 1ns later.
   task automatic run_table(input logic hold, input logic lock, input string tag);
      logic [31:0] c [2][2];
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) c[i][j] = 0;
      for (int r = 0; r < 6; r++) begin
         start = (r == 0) || hold;
         if (lock && r == 2) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 32'd99;
         end
         tick();
         wr_en = 1'b0;
         chk($sformatf("%s r%0d pe_clear", tag, r), {31'b0, pe_clear}, {31'b0, tbl[r].clr});
         chk($sformatf("%s r%0d feed_valid", tag, r), {31'b0, feed_valid}, {31'b0, tbl[r].fv});
         chk($sformatf("%s r%0d busy", tag, r), {31'b0, busy}, {31'b0, tbl[r].bz});
         chk($sformatf("%s r%0d done", tag, r), {31'b0, done}, {31'b0, tbl[r].dn});
         chk($sformatf("%s r%0d data0", tag, r), el2(data, 0), tbl[r].d0);
         chk($sformatf("%s r%0d data1", tag, r), el2(data, 1), tbl[r].d1);
         chk($sformatf("%s r%0d weight0", tag, r), el2(weight, 0), tbl[r].w0);
         chk($sformatf("%s r%0d weight1", tag, r), el2(weight, 1), tbl[r].w1);
         if (pe_clear)
            for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) c[i][j] = 0;
         if (feed_valid)
            for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++)
               c[i][j] = c[i][j] + el2(data, i) * el2(weight, j);
      end
      start = 1'b0;
      chk($sformatf("%s c00", tag), c[0][0], 32'd19);
      chk($sformatf("%s c01", tag), c[0][1], 32'd22);
      chk($sformatf("%s c10", tag), c[1][0], 32'd43);
      chk($sformatf("%s c11", tag), c[1][1], 32'd50);
      tick();
      chk($sformatf("%s idle pe_clear", tag), {31'b0, pe_clear}, 32'd0);
      chk($sformatf("%s idle busy", tag), {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int fv_cnt;
      tbl[0] = '{d0: 0, d1: 0, w0: 0, w1: 0, clr: 1, fv: 0, bz: 1, dn: 0};
      tbl[1] = '{d0: 1, d1: 3, w0: 5, w1: 6, clr: 0, fv: 1, bz: 1, dn: 0};
      tbl[2] = '{d0: 2, d1: 4, w0: 7, w1: 8, clr: 0, fv: 1, bz: 1, dn: 0};
      tbl[3] = '{d0: 0, d1: 0, w0: 0, w1: 0, clr: 0, fv: 0, bz: 1, dn: 0};
      tbl[4] = '{d0: 0, d1: 0, w0: 0, w1: 0, clr: 0, fv: 0, bz: 0, dn: 1};
      tbl[5] = '{d0: 0, d1: 0, w0: 0, w1: 0, clr: 0, fv: 0, bz: 0, dn: 0};

      reset = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; start = 0;
      wr_en3 = 0; wr_sel3 = 0; wr_addr3 = 0; wr_data3 = 0; start3 = 0;
      tick(); tick();
      chk("reset outs u1", {data, weight, feed_valid, pe_clear, busy, done} == '0 ? 32'd0 : 32'd1, 32'd0);
      chk("reset outs u3", {data3, weight3, fv3, clr3, busy3, done3} == '0 ? 32'd0 : 32'd1, 32'd0);
      reset = 1'b0;
      tick();

      load_basic();
      run_table(1'b0, 1'b0, "basic");
      run_table(1'b0, 1'b1, "lock");
      run_table(1'b0, 1'b0, "rerun");
      run_table(1'b1, 1'b0, "hold");

      // Abort during step 1: reset asserted between edges takes effect at once.
      start = 1'b1; tick(); start = 1'b0; tick(); tick();
      chk("abort pre feed_valid", {31'b0, feed_valid}, 32'd1);
      chk("abort pre data0", el2(data, 0), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("abort feed_valid", {31'b0, feed_valid}, 32'd0);
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort done", {31'b0, done}, 32'd0);
      chk("abort data", data == '0 ? 32'd0 : 32'd1, 32'd0);
      tick();
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk($sformatf("abort no done %0d", n), {31'b0, done | busy}, 32'd0);
      end

      // Buffers were cleared: a run with no writes streams zeros.
      fv_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (feed_valid) fv_cnt++;
         chk($sformatf("zero run data %0d", n), (data == '0 && weight == '0) ? 32'd0 : 32'd1, 32'd0);
      end
      chk("zero run steps", 32'(fv_cnt), 32'd2);
      tick();

      load_basic();
      run_table(1'b0, 1'b0, "reload");

      // wr_sel=1, wr_addr=3 targets B[1][1] which feeds weight[1] at step 1.
      wr(1'b1, 2'd3, 32'd80);
      start = 1'b1; tick(); start = 1'b0; tick(); tick();
      chk("b11 weight0", el2(weight, 0), 32'd7);
      chk("b11 weight1", el2(weight, 1), 32'd80);
      chk("b11 data1", el2(data, 1), 32'd4);
      repeat (4) tick();

      // DIM=3, PE_LAT=0: out-of-range addresses ignored, done right after last step.
      for (int i = 0; i < 3; i++) for (int kk = 0; kk < 3; kk++) begin
         wr3(1'b0, 4'(i * 3 + kk), 32'(10 * i + kk + 1));
         wr3(1'b1, 4'(i * 3 + kk), 32'(100 + 10 * i + kk));
      end
      for (int a = 9; a < 16; a++) begin
         wr3(1'b0, 4'(a), 32'hDEAD);
         wr3(1'b1, 4'(a), 32'hBEEF);
      end
      start3 = 1'b1; tick(); start3 = 1'b0;
      chk("d3 pe_clear", {31'b0, clr3}, 32'd1);
      for (int kk = 0; kk < 3; kk++) begin
         tick();
         chk($sformatf("d3 s%0d fv", kk), {31'b0, fv3}, 32'd1);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("d3 s%0d data%0d", kk, i), el3(data3, i), 32'(10 * i + kk + 1));
            chk($sformatf("d3 s%0d weight%0d", kk, i), el3(weight3, i), 32'(100 + 10 * kk + i));
         end
      end
      tick();
      chk("d3 done", {31'b0, done3}, 32'd1);
      chk("d3 done busy", {31'b0, busy3}, 32'd0);
      chk("d3 done fv", {31'b0, fv3}, 32'd0);
      tick();
      chk("d3 done pulse", {31'b0, done3}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Operand buffer and sequencer directly upstream of the DIM x DIM systolic array.
- Host loads matrix A (DIM x DIM) and matrix B (DIM x DIM) word by word. A start pulse then streams one column of A and the matching row of B per cycle for DIM cycles, driving the array's data/weight buses.
- Each PE accumulates C[i][j] = sum_k A[i][k]*B[k][j].
- A one-cycle clear pulse precedes the stream and a done pulse follows it. The top level ORs pe_clear into the array reset.

Parameters:
- DIM, 2, array dimension (rows = columns = DIM), DIM >= 1
- ADDR_W, 2, write address width, must satisfy 2^ADDR_W >= DIM*DIM
- PE_LAT, 1, drain cycles after the last operand before results are stable in the array, PE_LAT >= 0

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- wr_en  in  1  write strobe for the operand buffers
- wr_sel  in  1  buffer select: 0 = A, 1 = B
- wr_addr  in  ADDR_W  element index = row*DIM + col
- wr_data  in  32  operand word, opaque 32-bit value
- start  in  1  begin a run, sampled in IDLE only
- data  out  DIM*32  declared [0:DIM*32-1], element i at [i*32 +: 32], i.e. A[i][k] for array row i
- weight  out  DIM*32  declared [0:DIM*32-1], element j at [j*32 +: 32], i.e. B[k][j] for array column j
- feed_valid  out  1  data/weight carry a live operand step
- pe_clear  out  1  one-cycle accumulator clear to the array
- busy  out  1  run in progress
- done  out  1  one-cycle pulse: array results complete

Behaviour:
- Reset (async, asserts immediately):
  - state = IDLE, k = 0
  - data, weight, feed_valid, pe_clear, busy and done all go to 0
  - all A and B buffer words are cleared to 0
  - reset mid-run aborts silently, with no done pulse
- All outputs are registered. There is no combinational path from inputs to outputs.
- Writes:
  - accepted only when busy = 0 and done = 0 (state IDLE)
  - the buffer word at wr_sel/wr_addr updates at the clock edge
  - wr_addr >= DIM*DIM is ignored
  - writes while busy are dropped and the buffer is unchanged
  - a write and start in the same IDLE cycle: the write lands, and the run uses the new value
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
  - IDLE: start = 1 -> CLEAR. Otherwise stay. start is ignored in every other state.
  - CLEAR (1 cycle): pe_clear = 1, busy = 1, feed_valid = 0, data and weight = 0. Next state STREAM with k = 0.
  - STREAM (DIM cycles): feed_valid = 1, busy = 1, data[i] = A[i][k], weight[j] = B[k][j]. k increments each cycle. When k = DIM-1 the next state is DRAIN, or DONE if PE_LAT = 0.
  - DRAIN (PE_LAT cycles, down-counter): busy = 1, feed_valid = 0, data and weight = 0 (zeros keep the accumulators stable). Next state DONE.
  - DONE (1 cycle): done = 1, busy = 0. Next state IDLE.
- Timing: take start sampled at edge E0.
  - pe_clear is high after E0.
  - Step k is presented after E(1+k).
  - done is high after E(DIM+PE_LAT+1) for exactly one cycle.
  - Total run length: DIM + PE_LAT + 2 cycles from start to IDLE.
- Back-to-back: start held high through DONE does not retrigger. A new run needs start sampled in IDLE, so the earliest restart is the cycle after DONE.
- Buffers retain their contents after a run, so a rerun without rewrites gives an identical stream.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0 immediately. Later runs with no writes stream all zeros.
- Basic run, DIM=2, PE_LAT=1:
  - load A = [[1,2],[3,4]] at addr 0..3 and B = [[5,6],[7,8]], then pulse start
  - -> pe_clear after E0
  - -> step 0: data = {1,3}, weight = {5,6}
  - -> step 1: data = {2,4}, weight = {7,8}
  - -> done after E4. With the array attached, rout = {19,22,43,50}.
- Write lockout: during STREAM, write A addr 0 = 99 -> no effect. A rerun still streams data = {1,3} at step 0.
- Start while busy, and start held high through DONE -> exactly one done pulse, no extra pe_clear.
- Abort: assert reset during step 1 -> feed_valid, busy and done go to 0 at once with no done pulse. A reload of the same values plus start gives the exact basic-run sequence.
- Boundary:
  - wr_addr = 3 with wr_sel = 1 writes B[1][1]
  - DIM=3, ADDR_W=4: wr_addr = 9..15 ignored
  - PE_LAT=0: done immediately follows the last STREAM cycle.
